// File: rtl/alu_req_arbiter.sv
// ----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares a single ALU_TOP instance between two requesters. A round-robin
// arbiter accepts one operation at a time, drives the ALU operand/function
// registers, waits out the ALU pipeline latency, captures the result of the
// unit addressed by ALU_FUN[3:2] and returns it on a valid/ready response port.
//
// Ports
//   CLK_CTRL       clock, rising edge
//   RST_CTRL       asynchronous active-low reset
//   REQ_VALID[1:0] per-requester request valid
//   REQ_READY[1:0] per-requester accept strobe (one-hot or zero, IDLE only)
//   REQ_A/B/FUN    packed per-requester operands and function code
//   RSP_VALID      response valid, held until RSP_READY is sampled high
//   RSP_READY      response consumed
//   RSP_ID         requester owning the response
//   RSP_DATA       captured result, zero-extended to RES_W
//   RSP_ERR        addressed unit flag was low at capture
//   ALU_A/B/FUN    registered operands/function toward ALU_TOP
//   ALU_*_OUT      unit results from ALU_TOP
//   ALU_CARRY      arithmetic carry from ALU_TOP
//   ALU_FLAGS      {SHIFT, CMP, LOGIC, ARITH} unit-valid flags from ALU_TOP
// ----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int unsigned A_W     = 16,
    parameter int unsigned B_W     = 16,
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned RES_W   = A_W + B_W + 1
) (
    input  logic                 CLK_CTRL,
    input  logic                 RST_CTRL,
    input  logic [1:0]           REQ_VALID,
    output logic [1:0]           REQ_READY,
    input  logic [2*A_W-1:0]     REQ_A,
    input  logic [2*B_W-1:0]     REQ_B,
    input  logic [7:0]           REQ_FUN,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 RSP_ID,
    output logic [RES_W-1:0]     RSP_DATA,
    output logic                 RSP_ERR,
    output logic [A_W-1:0]       ALU_A,
    output logic [B_W-1:0]       ALU_B,
    output logic [3:0]           ALU_FUN,
    input  logic [A_W+B_W-1:0]   ALU_ARITH_OUT,
    input  logic                 ALU_CARRY,
    input  logic [A_W-1:0]       ALU_LOGIC_OUT,
    input  logic [2:0]           ALU_CMP_OUT,
    input  logic [A_W-1:0]       ALU_SHIFT_OUT,
    input  logic [3:0]           ALU_FLAGS
);

    // Counter must hold ALU_LAT-1; keep at least one bit when ALU_LAT is 1.
    localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,    state_d;
    logic             rr_q,       rr_d;
    logic [CntW-1:0]  cnt_q,      cnt_d;
    logic [A_W-1:0]   alu_a_q,    alu_a_d;
    logic [B_W-1:0]   alu_b_q,    alu_b_d;
    logic [3:0]       alu_fun_q,  alu_fun_d;
    logic             rsp_id_q,   rsp_id_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q,  rsp_err_d;

    // ------------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on contention the
    // round-robin pointer decides. The pointer itself only moves when a
    // response completes, so a lone grant never disturbs fairness.
    // ------------------------------------------------------------------------
    logic       gnt_id;
    logic       grant;
    logic [A_W-1:0] sel_a;
    logic [B_W-1:0] sel_b;
    logic [3:0]     sel_fun;

    always_comb begin
        gnt_id = 1'b0;
        case (REQ_VALID)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr_q;
            default: gnt_id = 1'b0;
        endcase
    end

    assign grant     = (state_q == StIdle) && (|REQ_VALID);
    assign REQ_READY = grant ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    assign sel_a   = gnt_id ? REQ_A[A_W +: A_W] : REQ_A[0 +: A_W];
    assign sel_b   = gnt_id ? REQ_B[B_W +: B_W] : REQ_B[0 +: B_W];
    assign sel_fun = gnt_id ? REQ_FUN[4 +: 4]   : REQ_FUN[0 +: 4];

    // ------------------------------------------------------------------------
    // Result capture mux, keyed by the unit-select bits of the held function.
    // ------------------------------------------------------------------------
    logic [RES_W-1:0] cap_data;
    logic             cap_err;

    always_comb begin
        cap_data = '0;
        unique case (alu_fun_q[3:2])
            2'b00:   cap_data = RES_W'({ALU_CARRY, ALU_ARITH_OUT});
            2'b01:   cap_data = RES_W'(ALU_LOGIC_OUT);
            2'b10:   cap_data = RES_W'(ALU_CMP_OUT);
            default: cap_data = RES_W'(ALU_SHIFT_OUT);
        endcase
        cap_err = ~ALU_FLAGS[alu_fun_q[3:2]];
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (grant) begin
                    alu_a_d   = sel_a;
                    alu_b_d   = sel_b;
                    alu_fun_d = sel_fun;
                    rsp_id_d  = gnt_id;
                    cnt_d     = CntW'(ALU_LAT - 1);
                    state_d   = StExec;
                end
            end
            StExec: begin
                // Operands stay put; the ALU output is only trusted once the
                // full latency has elapsed since they were applied.
                if (cnt_q == '0) begin
                    rsp_data_d = cap_data;
                    rsp_err_d  = cap_err;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (RSP_READY) begin
                    rr_d    = ~rsp_id_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
        if (!RST_CTRL) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign RSP_VALID = (state_q == StResp);
    assign RSP_ID    = rsp_id_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Drives alu_req_arbiter with directed and random traffic. A stand-in ALU
// produces deterministic unit outputs that only become valid ALU_LAT cycles
// after its inputs change (random junk before that), so early or late capture
// is visible. Expected responses come from a request-level model: grant
// choice, busy/idle tracking and result selection by function code.
// ----------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int unsigned A_W     = 16;
    localparam int unsigned B_W     = 16;
    localparam int unsigned ALU_LAT = 2;
    localparam int unsigned RES_W   = A_W + B_W + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [2*A_W-1:0] req_a = '0;
    logic [2*B_W-1:0] req_b = '0;
    logic [7:0]       req_fun = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_err;
    logic [A_W-1:0]   alu_a;
    logic [B_W-1:0]   alu_b;
    logic [3:0]       alu_fun;
    logic [31:0]      alu_arith;
    logic             alu_carry;
    logic [15:0]      alu_logic;
    logic [2:0]       alu_cmp;
    logic [15:0]      alu_shift;
    logic [3:0]       alu_flags;

    int n_chk = 0;
    int n_err = 0;
    bit force_flags = 1'b0;
    int grant_log[$];
    int grant_cyc[$];

    always #5 clk = ~clk;

    alu_req_arbiter #(
        .A_W    (A_W),
        .B_W    (B_W),
        .ALU_LAT(ALU_LAT),
        .RES_W  (RES_W)
    ) dut (
        .CLK_CTRL     (clk),
        .RST_CTRL     (rst_n),
        .REQ_VALID    (req_valid),
        .REQ_READY    (req_ready),
        .REQ_A        (req_a),
        .REQ_B        (req_b),
        .REQ_FUN      (req_fun),
        .RSP_VALID    (rsp_valid),
        .RSP_READY    (rsp_ready),
        .RSP_ID       (rsp_id),
        .RSP_DATA     (rsp_data),
        .RSP_ERR      (rsp_err),
        .ALU_A        (alu_a),
        .ALU_B        (alu_b),
        .ALU_FUN      (alu_fun),
        .ALU_ARITH_OUT(alu_arith),
        .ALU_CARRY    (alu_carry),
        .ALU_LOGIC_OUT(alu_logic),
        .ALU_CMP_OUT  (alu_cmp),
        .ALU_SHIFT_OUT(alu_shift),
        .ALU_FLAGS    (alu_flags)
    );

    // ---------------- stand-in ALU behaviour ----------------
    function automatic logic [31:0] f_arith(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        case (f[1:0])
            2'd0:    return 32'(a) + 32'(b);
            2'd1:    return 32'(a) - 32'(b);
            default: return 32'(a) * 32'(b);
        endcase
    endfunction

    function automatic logic f_carry(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        logic [16:0] s;
        s = 17'(a) + 17'(b);
        return (f[1:0] == 2'd0) ? s[16] : (a[15] ^ b[15]);
    endfunction

    function automatic logic [15:0] f_logic(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        return (a & b) ^ {12'h000, f};
    endfunction

    function automatic logic [2:0] f_cmp(logic [15:0] a, logic [15:0] b);
        return {a > b, a == b, a < b};
    endfunction

    function automatic logic [15:0] f_shift(logic [15:0] a, logic [3:0] f);
        return a << f[1:0];
    endfunction

    function automatic logic [3:0] f_flags(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        return {a[0] | b[1], ~(a[2] & b[2]), a[3] | b[0] | f[0], ~(a[1] & b[1])};
    endfunction

    logic [35:0] alu_prev;
    int          alu_stable = 0;
    logic [63:0] junk = '0;
    bit          alu_ok;

    always @(posedge clk) begin
        #1;
        if ({alu_a, alu_b, alu_fun} !== alu_prev) alu_stable = 1;
        else alu_stable = alu_stable + 1;
        alu_prev = {alu_a, alu_b, alu_fun};
        junk = {$urandom, $urandom};
    end

    assign alu_ok    = (alu_stable >= ALU_LAT);
    assign alu_arith = alu_ok ? f_arith(alu_a, alu_b, alu_fun) : junk[31:0];
    assign alu_carry = alu_ok ? f_carry(alu_a, alu_b, alu_fun) : junk[32];
    assign alu_logic = alu_ok ? f_logic(alu_a, alu_b, alu_fun) : junk[47:32];
    assign alu_cmp   = alu_ok ? f_cmp(alu_a, alu_b) : junk[50:48];
    assign alu_shift = alu_ok ? f_shift(alu_a, alu_fun) : junk[63:48];
    assign alu_flags = force_flags ? 4'b0000 :
                       (alu_ok ? f_flags(alu_a, alu_b, alu_fun) : junk[3:0]);

    // ---------------- reference model ----------------
    function automatic logic [RES_W-1:0] ref_data(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        case (f[3:2])
            2'd0:    return {f_carry(a, b, f), f_arith(a, b, f)};
            2'd1:    return RES_W'(f_logic(a, b, f));
            2'd2:    return RES_W'(f_cmp(a, b));
            default: return RES_W'(f_shift(a, f));
        endcase
    endfunction

    function automatic logic ref_err(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        logic [3:0] fl;
        fl = f_flags(a, b, f);
        return force_flags ? 1'b1 : ~fl[f[3:2]];
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        force_flags = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents one request for a single cycle; returns REQ_READY seen in that cycle.
    task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] f, output logic [1:0] rdy);
        @(negedge clk);
        req_valid = (id == 1) ? 2'b10 : 2'b01;
        if (id == 1) begin req_a[31:16] = a; req_b[31:16] = b; req_fun[7:4] = f; end
        else begin req_a[15:0] = a; req_b[15:0] = b; req_fun[3:0] = f; end
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid = '0;
    endtask

    // Counts cycles (accept cycle = 0) until RSP_VALID; -1 if it never shows.
    task automatic wait_rsp(output int lat);
        lat = 1;
        #1;
        while (!rsp_valid && lat < 30) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b v=%b id=%b err=%b want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_err);
        end
        n_chk++;
        if ({rsp_data, alu_a, alu_b, alu_fun} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got data=%h a=%h b=%h fun=%h want all 0",
                     rsp_data, alu_a, alu_b, alu_fun);
        end
        do_reset();
    endtask

    task automatic test_add();
        logic [1:0] rdy;
        int lat;
        do_reset();
        issue(0, 16'hFFFF, 16'h0001, 4'b0000, rdy);
        n_chk++;
        if (rdy !== 2'b01) begin
            n_err++; $display("FAIL add_ready: got %b want 01", rdy);
        end
        wait_rsp(lat);
        n_chk++;
        if (lat != int'(ALU_LAT) + 1) begin
            n_err++; $display("FAIL add_latency: got %0d want %0d", lat, ALU_LAT + 1);
        end
        n_chk++;
        if ({rsp_id, rsp_data, rsp_err} !== {1'b0, 33'h1_0001_0000, 1'b0}) begin
            n_err++;
            $display("FAIL add_rsp: got id=%b data=%h err=%b want id=0 data=100010000 err=0",
                     rsp_id, rsp_data, rsp_err);
        end
        consume();
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL add_rsp_drop: got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] rdy;
        int lat;
        logic [15:0] a, b;
        logic [3:0] f;
        logic [RES_W-1:0] exp_d;
        logic exp_e;
        do_reset();
        a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
        exp_d = ref_data(a, b, f);
        exp_e = ref_err(a, b, f);
        issue(1, a, b, f, rdy);
        n_chk++;
        if (rdy !== 2'b10) begin
            n_err++; $display("FAIL bp_ready_lone: got %b want 10", rdy);
        end
        // Both requesters now wait for the busy sequencer.
        req_valid = 2'b11;
        req_a = {16'($urandom), 16'($urandom)};
        req_b = {16'($urandom), 16'($urandom)};
        req_fun = 8'($urandom);
        wait_rsp(lat);
        n_chk++;
        if (lat != int'(ALU_LAT) + 1) begin
            n_err++; $display("FAIL bp_latency: got %0d want %0d", lat, ALU_LAT + 1);
        end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !==
                {1'b1, 1'b1, exp_d, exp_e, 2'b00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%b d=%h e=%b rdy=%b want 1 1 %h %b 00",
                         i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, exp_d, exp_e);
            end
            @(negedge clk);
            #1;
        end
        consume();
        #1;
        // Pointer moved past requester 1, so requester 0 wins the contention.
        n_chk++;
        if (req_ready !== 2'b01) begin
            n_err++; $display("FAIL bp_next_grant: got %b want 01", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_cmp();
        logic [1:0] rdy;
        int lat;
        do_reset();
        issue(0, 16'd5, 16'd9, 4'b1000, rdy);
        #1;
        n_chk++;
        if (alu_fun !== 4'b1000) begin
            n_err++; $display("FAIL cmp_fun_pass: got %b want 1000", alu_fun);
        end
        wait_rsp(lat);
        n_chk++;
        if (lat < 0 || rsp_data !== 33'd1) begin
            n_err++; $display("FAIL cmp_data: got lat=%0d data=%h want data=1", lat, rsp_data);
        end
        consume();
    endtask

    task automatic test_error();
        logic [1:0] rdy;
        int lat;
        logic [15:0] a, b;
        do_reset();
        force_flags = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        issue(1, a, b, 4'b0001, rdy);
        wait_rsp(lat);
        n_chk++;
        if (lat < 0 || {rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b1, ref_data(a, b, 4'b0001)}) begin
            n_err++;
            $display("FAIL err_flag: got lat=%0d id=%b err=%b data=%h want id=1 err=1 data=%h",
                     lat, rsp_id, rsp_err, rsp_data, ref_data(a, b, 4'b0001));
        end
        consume();
        force_flags = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] rdy;
        logic [15:0] a;
        do_reset();
        a = 16'($urandom) | 16'h0001;
        issue(0, a, 16'h1234, 4'b0110, rdy);
        #1;
        n_chk++;
        if (alu_a !== a) begin
            n_err++; $display("FAIL rst_exec_pre: got alu_a=%h want %h", alu_a, a);
        end
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, alu_a, alu_b, alu_fun} !== '0) begin
            n_err++;
            $display("FAIL rst_exec_async: got v=%b a=%h b=%h fun=%h data=%h want all 0",
                     rsp_valid, alu_a, alu_b, alu_fun, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if ({rsp_valid, req_ready} !== 3'b000) begin
                n_err++;
                $display("FAIL rst_exec_quiet[%0d]: got v=%b rdy=%b want 0 00",
                         i, rsp_valid, req_ready);
            end
        end
        rsp_ready = 1'b0;
    endtask

    // Cycle-accurate request-level model run alongside random/contending traffic.
    task automatic test_stream(input int n_ops, input bit contend, input bit rand_ready,
                               input string tag);
        logic [1:0] vld;
        logic [15:0] oa[2], ob[2];
        logic [3:0] of[2];
        bit busy;
        int age, done, g, m_rr;
        logic e_id, e_err, e_v;
        logic [RES_W-1:0] e_data;
        logic [1:0] e_rdy;
        do_reset();
        grant_log.delete();
        grant_cyc.delete();
        vld = '0; busy = 0; age = 0; done = 0; m_rr = 0;
        e_id = 0; e_err = 0; e_data = '0; g = 0;
        for (int cyc = 0; cyc < 3000 && done < n_ops; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!vld[i] && (contend || $urandom_range(0, 2) == 0)) begin
                    vld[i] = 1'b1;
                    oa[i] = 16'($urandom); ob[i] = 16'($urandom); of[i] = 4'($urandom);
                end
            end
            req_valid = vld;
            req_a = {oa[1], oa[0]};
            req_b = {ob[1], ob[0]};
            req_fun = {of[1], of[0]};
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            e_rdy = '0;
            if (!busy && vld != 2'b00) begin
                g = (vld == 2'b11) ? m_rr : (vld[1] ? 1 : 0);
                e_rdy[g] = 1'b1;
            end
            e_v = busy && (age >= int'(ALU_LAT) + 1);
            n_chk++;
            if (req_ready !== e_rdy) begin
                n_err++;
                $display("FAIL %s_req_ready: cycle %0d got %b want %b", tag, cyc, req_ready, e_rdy);
            end
            n_chk++;
            if (rsp_valid !== e_v) begin
                n_err++;
                $display("FAIL %s_rsp_valid: cycle %0d got %b want %b", tag, cyc, rsp_valid, e_v);
            end
            if (e_v) begin
                n_chk++;
                if ({rsp_id, rsp_data, rsp_err} !== {e_id, e_data, e_err}) begin
                    n_err++;
                    $display("FAIL %s_rsp: cycle %0d got id=%b d=%h e=%b want id=%b d=%h e=%b",
                             tag, cyc, rsp_id, rsp_data, rsp_err, e_id, e_data, e_err);
                end
            end
            if (busy) age++;
            if (e_rdy != 2'b00) begin
                busy = 1; age = 1;
                e_id = 1'(g);
                e_data = ref_data(oa[g], ob[g], of[g]);
                e_err = ref_err(oa[g], ob[g], of[g]);
                vld[g] = 1'b0;
                grant_log.push_back(g);
                grant_cyc.push_back(cyc);
            end else if (e_v && rsp_ready) begin
                busy = 0;
                m_rr = e_id ? 0 : 1;
                done++;
            end
        end
        n_chk++;
        if (done != n_ops) begin
            n_err++; $display("FAIL %s_timeout: got %0d ops want %0d", tag, done, n_ops);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_contention();
        test_stream(4, 1'b1, 1'b0, "contend");
        n_chk++;
        if (grant_log.size() != 4) begin
            n_err++; $display("FAIL contend_count: got %0d grants want 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (grant_log[i] != i % 2) begin
                    n_err++;
                    $display("FAIL contend_order[%0d]: got %0d want %0d", i, grant_log[i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (grant_cyc[i+1] - grant_cyc[i] != int'(ALU_LAT) + 2) begin
                    n_err++;
                    $display("FAIL contend_rate[%0d]: got %0d cycles want %0d",
                             i, grant_cyc[i+1] - grant_cyc[i], ALU_LAT + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        test_stream(40, 1'b0, 1'b1, "random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_backpressure();
        test_cmp();
        test_error();
        test_reset_mid_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
